// File: rtl/tpulse_stretch_tx_pkg.sv
//------------------------------------------------------------------------------
// Module   : tpulse_stretch_tx_pkg
// Brief    : Shared FSM encoding and timer sizing for the pulse-stretch TX.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tpulse_stretch_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HOLD     = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_GAP      = 2'd3
   } state_t;

   // Timer only ever holds (max-1), so clog2(max) bits suffice; never below one bit.
   function automatic int timer_w(input int del, input int gap);
      int m;
      m = (del > gap) ? del : gap;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tpulse_stretch_tx_if.sv
//------------------------------------------------------------------------------
// Module   : tpulse_stretch_tx_if
// Brief    : Event request / stretched level bundle of the pulse-stretch TX.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tpulse_stretch_tx_if #(
   parameter int PEND_W = 4
);
   logic              i_signal_in;
   logic              i_ack_in;
   logic              o_signal_out;
   logic              o_busy;
   logic [PEND_W-1:0] o_pend_cnt;
   logic              o_overflow;

   modport master (
      output i_signal_in,
      output i_ack_in,
      input  o_signal_out,
      input  o_busy,
      input  o_pend_cnt,
      input  o_overflow
   );

   modport slave (
      input  i_signal_in,
      input  i_ack_in,
      output o_signal_out,
      output o_busy,
      output o_pend_cnt,
      output o_overflow
   );
endinterface

`default_nettype wire

// File: rtl/tpulse_stretch_tx_sync.sv
//------------------------------------------------------------------------------
// Module   : tsync_bit
// Brief    : SYNC_STG-deep single-bit synchroniser, async active-low reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tsync_bit #(
   parameter int SYNC_STG = 2
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_d,
   output logic      o_q
);

   logic [SYNC_STG-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STG-2:0], i_d};
      end
   end

   assign o_q = r_sync[SYNC_STG-1];

endmodule

`default_nettype wire

// File: rtl/tpulse_stretch_tx.sv
//------------------------------------------------------------------------------
// Module   : tpulse_stretch_tx
// Brief    : Queues 1-cycle events and emits each as a stretched level with
//            guaranteed high time and low gap. Macro TPULSE_ACK_EN closes the
//            loop with a synchronised 4-phase acknowledge.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tpulse_stretch_tx
   import tpulse_stretch_tx_pkg::*;
#(
   parameter int VAL_DEL  = 10,
   parameter int VAL_GAP  = 3,
   parameter int PEND_W   = 4,
   parameter int SYNC_STG = 2
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   tpulse_stretch_tx_if.slave  bus
);

   localparam int              TW         = timer_w(VAL_DEL, VAL_GAP);
   localparam logic [TW-1:0]   c_DEL_LOAD = TW'(VAL_DEL - 1);
   localparam logic [TW-1:0]   c_GAP_LOAD = TW'(VAL_GAP - 1);
   localparam logic [PEND_W-1:0] c_PEND_MAX = '1;

   state_t              r_state;
   logic [TW-1:0]       r_timer;
   logic [PEND_W-1:0]   r_pend;
   logic                r_out;
   logic                r_busy;
   logic                r_ovf;

   logic                w_gap_done;
   logic                w_can_launch;
   logic                w_have_event;
   logic                w_launch;
   logic                w_dec;
   logic                w_inc;

`ifdef TPULSE_ACK_EN
   logic                w_ack_s;

   tsync_bit #(
      .SYNC_STG (SYNC_STG)
   ) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.i_ack_in),
      .o_q   (w_ack_s)
   );

   // Four-phase: the far side must have dropped its ack before the next event.
   assign w_gap_done = (r_timer == '0) && !w_ack_s;
`else
   logic                w_unused_ack;

   assign w_unused_ack = bus.i_ack_in;
   assign w_gap_done   = (r_timer == '0);
`endif

   // A launch may coincide with the GAP exit so the low time is exactly VAL_GAP.
   assign w_can_launch = (r_state == ST_IDLE) || ((r_state == ST_GAP) && w_gap_done);
   assign w_have_event = bus.i_signal_in || (r_pend != '0);
   assign w_launch     = w_can_launch && w_have_event;
   assign w_dec        = w_launch && (r_pend != '0);
   assign w_inc        = bus.i_signal_in && !(w_launch && (r_pend == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_pend  <= '0;
         r_out   <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_ovf <= 1'b0;

         if (w_inc && !w_dec) begin
            if (r_pend == c_PEND_MAX) begin
               r_ovf <= 1'b1;
            end else begin
               r_pend <= r_pend + 1'b1;
            end
         end else if (w_dec && !w_inc) begin
            r_pend <= r_pend - 1'b1;
         end

         if (w_launch) begin
            r_state <= ST_HOLD;
            r_out   <= 1'b1;
            r_busy  <= 1'b1;
            r_timer <= c_DEL_LOAD;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_out  <= 1'b0;
                  r_busy <= 1'b0;
               end
               ST_HOLD: begin
                  if (r_timer != '0) begin
                     r_timer <= r_timer - 1'b1;
                  end else begin
`ifdef TPULSE_ACK_EN
                     if (w_ack_s) begin
                        r_state <= ST_GAP;
                        r_out   <= 1'b0;
                        r_timer <= c_GAP_LOAD;
                     end else begin
                        r_state <= ST_WAIT_ACK;
                     end
`else
                     r_state <= ST_GAP;
                     r_out   <= 1'b0;
                     r_timer <= c_GAP_LOAD;
`endif
                  end
               end
`ifdef TPULSE_ACK_EN
               ST_WAIT_ACK: begin
                  if (w_ack_s) begin
                     r_state <= ST_GAP;
                     r_out   <= 1'b0;
                     r_timer <= c_GAP_LOAD;
                  end
               end
`endif
               ST_GAP: begin
                  if (r_timer != '0) begin
                     r_timer <= r_timer - 1'b1;
                  end else if (w_gap_done) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_out   <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.o_signal_out = r_out;
   assign bus.o_busy       = r_busy;
   assign bus.o_pend_cnt   = r_pend;
   assign bus.o_overflow   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_tpulse_stretch_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_tpulse_stretch_tx
// Brief    : Directed, table-driven bench for tpulse_stretch_tx.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tpulse_stretch_tx;

   localparam int SYNC_STG = 2;

   typedef struct packed {
      logic       sig;
      logic       out;
      logic       busy;
      logic [3:0] pend;
      logic       ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   tpulse_stretch_tx_if #(.PEND_W(4)) bus0 ();
   tpulse_stretch_tx_if #(.PEND_W(2)) bus1 ();

   tpulse_stretch_tx #(.VAL_DEL(10), .VAL_GAP(3), .PEND_W(4), .SYNC_STG(SYNC_STG)) dut0 (
      .clk (clk), .rst_n (rst_n), .bus (bus0)
   );
   tpulse_stretch_tx #(.VAL_DEL(10), .VAL_GAP(3), .PEND_W(2), .SYNC_STG(SYNC_STG)) dut1 (
      .clk (clk), .rst_n (rst_n), .bus (bus1)
   );

   task automatic push(input int n, input logic sig, input logic out, input logic busy,
                       input int pend, input logic ovf);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.sig  = (i == 0) ? sig : 1'b0;
         v.out  = out;
         v.busy = busy;
         v.pend = 4'(pend);
         v.ovf  = ovf;
         tbl.push_back(v);
      end
   endtask

   task automatic compare(input int sel, input string name, input int idx, input vec_t v);
      logic       g_out, g_busy, g_ovf;
      logic [3:0] g_pend;
      if (sel == 0) begin
         g_out = bus0.o_signal_out; g_busy = bus0.o_busy;
         g_pend = bus0.o_pend_cnt;  g_ovf = bus0.o_overflow;
      end else begin
         g_out = bus1.o_signal_out; g_busy = bus1.o_busy;
         g_pend = {2'b00, bus1.o_pend_cnt}; g_ovf = bus1.o_overflow;
      end
      checks++;
      if (g_out !== v.out || g_busy !== v.busy || g_pend !== v.pend || g_ovf !== v.ovf) begin
         failures++;
         $display("FAIL %s[%0d] got out=%b busy=%b pend=%0d ovf=%b expected out=%b busy=%b pend=%0d ovf=%b",
                  name, idx, g_out, g_busy, g_pend, g_ovf, v.out, v.busy, v.pend, v.ovf);
      end
   endtask

   // Drive one vector's input, clock once, check outputs 1 time unit after the edge.
   task automatic step(input int sel, input string name, input int idx, input vec_t v);
      if (sel == 0) bus0.i_signal_in = v.sig;
      else          bus1.i_signal_in = v.sig;
      @(posedge clk);
      #1;
      compare(sel, name, idx, v);
   endtask

   task automatic run_tbl(input int sel, input string name);
      for (int i = 0; i < tbl.size(); i++) step(sel, name, i, tbl[i]);
      bus0.i_signal_in = 1'b0;
      bus1.i_signal_in = 1'b0;
      tbl.delete();
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b expected=%b", name, got, exp);
      end
   endtask

   initial begin
      vec_t zero;
      zero = '0;
      bus0.i_signal_in = 1'b0; bus0.i_ack_in = 1'b0;
      bus1.i_signal_in = 1'b0; bus1.i_ack_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, "reset0", 0, zero);
      step(1, "reset1", 0, zero);

`ifndef TPULSE_ACK_EN
      // Single event: 10 high, 3 low, busy 13 cycles.
      push(1, 1, 1, 1, 0, 0); push(9, 0, 1, 1, 0, 0);
      push(3, 0, 0, 1, 0, 0); push(2, 0, 0, 0, 0, 0);
      run_tbl(0, "single");

      // Burst of 4: pend peaks at 3, four back-to-back pulses.
      push(1, 1, 1, 1, 0, 0); push(1, 1, 1, 1, 1, 0); push(1, 1, 1, 1, 2, 0);
      push(1, 1, 1, 1, 3, 0); push(6, 0, 1, 1, 3, 0); push(3, 0, 0, 1, 3, 0);
      for (int p = 2; p >= 0; p--) begin
         push(10, 0, 1, 1, p, 0); push(3, 0, 0, 1, p, 0);
      end
      push(2, 0, 0, 0, 0, 0);
      run_tbl(0, "burst");

      // New event on the GAP exit cycle with one queued: net pend change zero.
      push(1, 1, 1, 1, 0, 0); push(1, 1, 1, 1, 1, 0); push(8, 0, 1, 1, 1, 0);
      push(3, 0, 0, 1, 1, 0); push(1, 1, 1, 1, 1, 0); push(9, 0, 1, 1, 1, 0);
      push(3, 0, 0, 1, 1, 0); push(10, 0, 1, 1, 0, 0); push(3, 0, 0, 1, 0, 0);
      push(2, 0, 0, 0, 0, 0);
      run_tbl(0, "simul");

      // PEND_W=2: 6 events -> 1 launched, 3 queued, 2 dropped.
      push(1, 1, 1, 1, 0, 0); push(1, 1, 1, 1, 1, 0); push(1, 1, 1, 1, 2, 0);
      push(1, 1, 1, 1, 3, 0); push(1, 1, 1, 1, 3, 1); push(1, 1, 1, 1, 3, 1);
      push(4, 0, 1, 1, 3, 0); push(3, 0, 0, 1, 3, 0);
      for (int p = 2; p >= 0; p--) begin
         push(10, 0, 1, 1, p, 0); push(3, 0, 0, 1, p, 0);
      end
      push(2, 0, 0, 0, 0, 0);
      run_tbl(1, "ovf");
`else
      // Ack round trip: ack rises after 25 high cycles, falls 7 cycles after signal_out.
      begin
         vec_t v;
         v = '0; v.sig = 1'b1; v.out = 1'b1; v.busy = 1'b1;
         step(0, "ack_launch", 0, v);
         bus0.i_signal_in = 1'b0;
         for (int k = 1; k < 25; k++) begin
            @(posedge clk); #1;
            check_bit("ack_hold_high", bus0.o_signal_out, 1'b1);
         end
         bus0.i_ack_in = 1'b1;
         for (int k = 0; k < SYNC_STG; k++) begin
            @(posedge clk); #1;
            check_bit("ack_sync_high", bus0.o_signal_out, 1'b1);
         end
         @(posedge clk); #1;
         check_bit("ack_fall", bus0.o_signal_out, 1'b0);
         for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            check_bit("ack_gap_busy", bus0.o_busy, 1'b1);
         end
         bus0.i_ack_in = 1'b0;
         for (int k = 0; k < SYNC_STG; k++) begin
            @(posedge clk); #1;
            check_bit("ack_gap_wait", bus0.o_busy, 1'b1);
         end
         @(posedge clk); #1;
         check_bit("ack_gap_exit", bus0.o_busy, 1'b0);
      end
`endif

      // Reset mid-HOLD with two events queued.
      begin
         vec_t v;
         v = '0; v.out = 1'b1; v.busy = 1'b1;
         v.sig = 1'b1; v.pend = 4'd0; step(0, "rst_pre", 0, v);
         v.sig = 1'b1; v.pend = 4'd1; step(0, "rst_pre", 1, v);
         v.sig = 1'b1; v.pend = 4'd2; step(0, "rst_pre", 2, v);
         v.sig = 1'b0;                step(0, "rst_pre", 3, v);
         #2;
         rst_n = 1'b0;
         #1;
         compare(0, "rst_async", 0, zero);
         @(posedge clk); #1;
         rst_n = 1'b1;
         for (int i = 0; i < 20; i++) step(0, "rst_after", i, zero);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/tpulse_stretch_tx.md
Name: tpulse_stretch_tx

Overview:
- Source-domain transmit end of the pulse-crossing path.
- Accepts 1-cycle event pulses and queues them in a pending counter.
- Emits each event as a stretched level on signal_out, which a far-domain synchroniser/debouncer/edge-detector chain converts back into one pulse.
- Enforces a minimum high time and a minimum low gap so back-to-back events are never merged. Optionally closes the loop with an acknowledge returned from the far side.

Parameters:
- VAL_DEL, 10: minimum cycles signal_out is held high per event (>=1).
- VAL_GAP, 3: minimum cycles signal_out is held low between events (>=1); must exceed the far-side debounce count.
- PEND_W, 4: pending-counter width; capacity 2^PEND_W-1 queued events.
- SYNC_STG, 2: flip-flop stages on ack_in (>=2).

Ports:
- clk  in  1  source-domain clock.
- rst  in  1  asynchronous, active-low reset.
- signal_in  in  1  event request; each high cycle is one event.
- ack_in  in  1  asynchronous level from the far domain; high once the far side has seen signal_out high. Used only with the optional feature.
- signal_out  out  1  stretched event level (registered).
- busy  out  1  high in any state other than IDLE.
- pend_cnt  out  PEND_W  number of queued events not yet launched.
- overflow  out  1  1-cycle pulse when an event is dropped because the queue is full.

Behaviour:
- Reset (rst low, async): state=IDLE; signal_out=0, busy=0, pend_cnt=0, overflow=0; timer=0; ack synchroniser cleared to 0.
- FSM states: IDLE, HOLD, WAIT_ACK, GAP.
- IDLE: launch if signal_in=1 or pend_cnt>0.
  - On launch: next cycle state=HOLD, signal_out=1, timer=VAL_DEL-1.
  - Latency: signal_in at edge N -> signal_out=1 after edge N+1.
- HOLD: timer decrements each cycle. At timer=0 go to WAIT_ACK (feature on) or GAP (feature off). Total high time is exactly VAL_DEL cycles with the feature off.
- WAIT_ACK: signal_out stays 1 until ack_s=1 (the synchronised ack_in). Then signal_out=0, state=GAP, timer=VAL_GAP-1.
- GAP: signal_out=0; timer decrements.
  - Exit to IDLE when timer=0 (and, feature on, ack_s=0).
  - The next launch can occur in the same cycle as the exit, so the minimum low time is exactly VAL_GAP cycles.
- Pending counter:
  - Increments on signal_in=1 unless that event is consumed by a launch in the same cycle.
  - Decrements when a launch is taken from the queue.
  - signal_in=1 with a queued launch in the same cycle: net zero change.
- Saturation: at 2^PEND_W-1 an incoming event is dropped, pend_cnt holds, and overflow pulses for 1 cycle.
- signal_in during HOLD/WAIT_ACK/GAP is always queued; it never extends the current pulse.
- Reset mid-pulse: signal_out drops immediately (async) and the queue is lost.

Optional Feature:
- Macro: TPULSE_ACK_EN.
- Defined:
  - WAIT_ACK is used and ack_in goes through a SYNC_STG-stage synchroniser.
  - GAP also waits for ack_s=0, giving a full 4-phase handshake. signal_out high time = max(VAL_DEL, ack round-trip).
- Undefined:
  - WAIT_ACK is unreachable and is removed; ack_in is unused.
  - Timing is open-loop: VAL_DEL high, VAL_GAP low.

Decomposition:
- Shared package: FSM state enum (IDLE/HOLD/WAIT_ACK/GAP, 2-bit encoding); a function computing the timer width as clog2(max(VAL_DEL,VAL_GAP)).
- Sub-module tsync_bit: SYNC_STG-deep, async active-low reset synchroniser. It is reused by the receive side of the crossing.

Test Plan:
- Single event, feature off, defaults: signal_in 1 cycle at edge 5 -> signal_out high from edge 6 through edge 15 (10 cycles), low >=3 cycles, busy high for 13 cycles, pend_cnt stays 0.
- Burst: signal_in high 4 consecutive cycles -> pend_cnt peaks at 3 -> exactly 4 pulses of 10 high/3 low, back to back; pend_cnt returns to 0.
- Overflow, PEND_W=2: 6 events in 6 cycles -> 1 launched, 3 queued, 2 dropped -> overflow pulses twice, 4 total pulses out.
- Simultaneous: signal_in=1 on the GAP->IDLE exit cycle with pend_cnt=1 -> queued event launches, pend_cnt stays 1.
- TPULSE_ACK_EN: ack_in rises 25 cycles after signal_out -> signal_out high 25+SYNC_STG cycles, falls; ack_in falls 7 cycles later -> GAP exits only after ack_s=0.
- Reset asserted mid-HOLD with pend_cnt=2 -> signal_out, busy, pend_cnt all 0 immediately; no pulse after release.
